// File: rtl/zap_sync_fifo_lvl.sv
// Synchronous FIFO with occupancy level, run-time almost-full/empty thresholds, flush,
// sticky overflow/underflow flags, FWFT or registered read. Optional peak via ZAP_SYNC_FIFO_LVL_PEAK_EN.
module zap_sync_fifo_lvl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter bit FWFT  = 1'b1,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ack,
    output logic [WIDTH-1:0] o_data,
    input  logic [LW-1:0]    i_af_lvl,
    input  logic [LW-1:0]    i_ae_lvl,
    output logic             o_empty,
    output logic             o_empty_n,
    output logic             o_full,
    output logic             o_full_n,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic [LW-1:0]    o_level,
    output logic             o_ovf,
    output logic             o_udf,
    output logic [LW-1:0]    o_peak
);

    localparam int AW = LW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [LW-1:0]    wptr_q, wptr_d;
    logic [LW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             push, pop;

    always_comb begin
        push    = i_wr_en && !full_q;
        pop     = i_ack && !empty_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        data_d  = data_q;

        if (i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            level_d = level_q + LW'(push) - LW'(pop);
            ovf_d   = ovf_q | (i_wr_en & full_q);
            udf_d   = udf_q | (i_ack & empty_q);
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == LW'(DEPTH));
        af_d    = (level_d >= i_af_lvl);
        ae_d    = (level_d <= i_ae_lvl);

        // FWFT: the new head is either already in memory or is the word being written right now
        if (FWFT) begin
            if (!i_flush && level_d != '0) begin
                if (push && wptr_q == rptr_d) data_d = i_data;
                else                          data_d = mem_q[rptr_d[AW-1:0]];
            end
        end else if (!i_flush && pop) begin
            data_d = mem_q[rptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) mem_q[wptr_q[AW-1:0]] <= i_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            data_q  <= data_d;
        end
    end

`ifdef ZAP_SYNC_FIFO_LVL_PEAK_EN
    logic [LW-1:0] peak_q, peak_d;

    // level never exceeds DEPTH, so the max also saturates there
    always_comb begin
        peak_d = peak_q;
        if (i_flush)               peak_d = '0;
        else if (level_d > peak_q) peak_d = level_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) peak_q <= '0;
        else         peak_q <= peak_d;
    end

    assign o_peak = peak_q;
`else
    assign o_peak = '0;
`endif

    assign o_data         = data_q;
    assign o_empty        = empty_q;
    assign o_empty_n      = ~empty_q;
    assign o_full         = full_q;
    assign o_full_n       = ~full_q;
    assign o_almost_full  = af_q;
    assign o_almost_empty = ae_q;
    assign o_level        = level_q;
    assign o_ovf          = ovf_q;
    assign o_udf          = udf_q;

endmodule

// File: tb/tb_zap_sync_fifo_lvl.sv
// Bench for zap_sync_fifo_lvl: FWFT=1 and FWFT=0 instances (DEPTH=4, WIDTH=8) on shared stimulus,
// a directed vector table, hand sequences, and random traffic against a queue-based model.
module tb_zap_sync_fifo_lvl;

    localparam int LW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0, wr = 1'b0, ack = 1'b0;
    logic [7:0] din = 8'h00;
    logic [2:0] af_lvl = 3'd3, ae_lvl = 3'd1;

    logic [7:0] o1_data, o0_data;
    logic       e1, en1, f1, fn1, af1, ae1, ov1, ud1;
    logic       e0, en0, f0, fn0, af0, ae0, ov0, ud0;
    logic [2:0] lv1, pk1, lv0, pk0;

    always #5 clk = ~clk;

    zap_sync_fifo_lvl #(.WIDTH(8), .DEPTH(4), .FWFT(1'b1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_wr_en(wr), .i_data(din), .i_ack(ack),
        .o_data(o1_data), .i_af_lvl(af_lvl), .i_ae_lvl(ae_lvl),
        .o_empty(e1), .o_empty_n(en1), .o_full(f1), .o_full_n(fn1),
        .o_almost_full(af1), .o_almost_empty(ae1), .o_level(lv1),
        .o_ovf(ov1), .o_udf(ud1), .o_peak(pk1));

    zap_sync_fifo_lvl #(.WIDTH(8), .DEPTH(4), .FWFT(1'b0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_wr_en(wr), .i_data(din), .i_ack(ack),
        .o_data(o0_data), .i_af_lvl(af_lvl), .i_ae_lvl(ae_lvl),
        .o_empty(e0), .o_empty_n(en0), .o_full(f0), .o_full_n(fn0),
        .o_almost_full(af0), .o_almost_empty(ae0), .o_level(lv0),
        .o_ovf(ov0), .o_udf(ud0), .o_peak(pk0));

    int n_cmp = 0;
    int n_err = 0;

    // reference model: a queue of stored words plus the registered flags
    logic [7:0] q[$];
    logic       m_ovf, m_udf, m_af, m_ae;
    int         m_peak;
    logic [7:0] m_d0;

    typedef struct {
        logic       wr, ack, fl;
        logic [7:0] din;
        logic [2:0] lvl;
        logic       e, f, af, ae, ov, ud, ck;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mkv(input logic w, input logic a, input logic fl, input logic [7:0] d,
                                 input logic [2:0] l, input logic e, input logic f, input logic xf,
                                 input logic xe, input logic ov, input logic ud, input logic ck,
                                 input logic [7:0] o);
        vec_t v;
        v.wr = w; v.ack = a; v.fl = fl; v.din = d; v.lvl = l; v.e = e; v.f = f;
        v.af = xf; v.ae = xe; v.ov = ov; v.ud = ud; v.ck = ck; v.dout = o;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_af = 1'b0; m_ae = 1'b1; m_peak = 0; m_d0 = 8'h00;
    endtask

    task automatic model_step();
        int sz;
        if (flush) begin
            q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_peak = 0;
        end else begin
            sz = q.size();
            if (wr && sz == 4) m_ovf = 1'b1;
            if (ack && sz == 0) m_udf = 1'b1;
            if (ack && sz > 0) m_d0 = q.pop_front();
            if (wr && sz < 4) q.push_back(din);
        end
        sz = q.size();
        m_af = (sz >= int'(af_lvl));
        m_ae = (sz <= int'(ae_lvl));
`ifdef ZAP_SYNC_FIFO_LVL_PEAK_EN
        if (sz > m_peak) m_peak = sz;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string nm);
        int sz = q.size();
        chk({nm, ".level"}, 32'(lv1), 32'(sz));
        chk({nm, ".empty"}, 32'({e1, en1}), 32'({sz == 0, sz != 0}));
        chk({nm, ".full"}, 32'({f1, fn1}), 32'({sz == 4, sz != 4}));
        chk({nm, ".af_ae"}, 32'({af1, ae1}), 32'({m_af, m_ae}));
        chk({nm, ".ovf_udf"}, 32'({ov1, ud1}), 32'({m_ovf, m_udf}));
        chk({nm, ".peak"}, 32'(pk1), 32'(m_peak));
        chk({nm, ".d0"}, 32'(o0_data), 32'(m_d0));
        chk({nm, ".lvl0"}, 32'({lv0, e0, f0, ov0, ud0}), 32'({lv1, e1, f1, ov1, ud1}));
        if (sz > 0) chk({nm, ".d1"}, 32'(o1_data), 32'(q[0]));
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, ".empty"}, 32'({e1, en1, e0, en0}), 32'(4'b1010));
        chk({nm, ".full"}, 32'({f1, fn1, f0, fn0}), 32'(4'b0101));
        chk({nm, ".level"}, 32'({lv1, lv0}), 32'(0));
        chk({nm, ".ae_af"}, 32'({ae1, af1, ae0, af0}), 32'(4'b1010));
        chk({nm, ".ovf_udf"}, 32'({ov1, ud1, ov0, ud0}), 32'(0));
        chk({nm, ".peak"}, 32'({pk1, pk0}), 32'(0));
        chk({nm, ".data"}, 32'({o1_data, o0_data}), 32'(0));
    endtask

    initial begin
        logic [7:0] exp_d;

        vecs[0]  = mkv(1'b1, 1'b0, 1'b0, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
        vecs[1]  = mkv(1'b1, 1'b0, 1'b0, 8'h22, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
        vecs[2]  = mkv(1'b1, 1'b0, 1'b0, 8'h33, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
        vecs[3]  = mkv(1'b1, 1'b0, 1'b0, 8'h44, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
        vecs[4]  = mkv(1'b1, 1'b0, 1'b0, 8'h55, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
        vecs[5]  = mkv(1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22);
        vecs[6]  = mkv(1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33);
        vecs[7]  = mkv(1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44);
        vecs[8]  = mkv(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        vecs[9]  = mkv(1'b1, 1'b1, 1'b0, 8'hA5, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5);
        vecs[10] = mkv(1'b1, 1'b0, 1'b0, 8'hB1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5);
        vecs[11] = mkv(1'b1, 1'b0, 1'b0, 8'hB2, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5);
        vecs[12] = mkv(1'b1, 1'b0, 1'b0, 8'hB3, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5);
        vecs[13] = mkv(1'b1, 1'b1, 1'b0, 8'hC0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB1);
        vecs[14] = mkv(1'b1, 1'b1, 1'b1, 8'hDD, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        vecs[15] = mkv(1'b1, 1'b0, 1'b0, 8'h66, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h66);

        #1 rst = 1'b1;
        model_reset();
        #1 check_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            wr = vecs[i].wr; ack = vecs[i].ack; flush = vecs[i].fl; din = vecs[i].din;
            tick();
            chk($sformatf("vec%0d.level", i), 32'(lv1), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d.ef", i), 32'({e1, f1}), 32'({vecs[i].e, vecs[i].f}));
            chk($sformatf("vec%0d.afae", i), 32'({af1, ae1}), 32'({vecs[i].af, vecs[i].ae}));
            chk($sformatf("vec%0d.ovud", i), 32'({ov1, ud1}), 32'({vecs[i].ov, vecs[i].ud}));
            if (vecs[i].ck) chk($sformatf("vec%0d.data", i), 32'(o1_data), 32'(vecs[i].dout));
            chk($sformatf("vec%0d.d0", i), 32'(o0_data), 32'(m_d0));
            chk($sformatf("vec%0d.peak", i), 32'(pk1), 32'(m_peak));
        end
`ifdef ZAP_SYNC_FIFO_LVL_PEAK_EN
        chk("peak_after_fill", 32'(pk1), 32'(4));
`endif

        // wrap-around: push/pop pairs at level 1 walk the pointers past 2*DEPTH
        for (int i = 0; i < 10; i++) begin
            wr = 1'b1; ack = 1'b1; flush = 1'b0; din = 8'(i);
            tick();
            exp_d = (i == 0) ? 8'h66 : 8'(i - 1);
            chk($sformatf("wrap%0d.data", i), 32'(o1_data), 32'(i));
            chk($sformatf("wrap%0d.state", i), 32'({lv1, e1, f1}), 32'({3'd1, 1'b0, 1'b0}));
            chk($sformatf("wrap%0d.d0", i), 32'(o0_data), 32'(exp_d));
        end

        // registered read: load on pop edge, hold otherwise
        wr = 1'b0; ack = 1'b1; tick();
        chk("rr.pop9", 32'({o0_data, e0}), 32'({8'h09, 1'b1}));
        wr = 1'b1; ack = 1'b0; din = 8'h7E; tick();
        chk("rr.hold_on_push", 32'(o0_data), 32'(8'h09));
        wr = 1'b0; ack = 1'b1; tick();
        chk("rr.pop7e", 32'(o0_data), 32'(8'h7E));
        ack = 1'b0; tick();
        chk("rr.held", 32'({o0_data, e0}), 32'({8'h7E, 1'b1}));

        // async reset between edges
        wr = 1'b1; din = 8'h3C; tick();
        din = 8'h3D; tick();
        wr = 1'b0; ack = 1'b1; tick();
        check_model("pre_rst");
        ack = 1'b0;
        #3 rst = 1'b1;
        model_reset();
        #1 check_reset_vals("async_rst");
        rst = 1'b0;

        for (int c = 0; c < 500; c++) begin
            int wb = (c < 250) ? 70 : 35;
            wr    = ($urandom_range(0, 99) < wb);
            ack   = ($urandom_range(0, 99) < 100 - wb);
            flush = ($urandom_range(0, 49) == 0);
            din   = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                af_lvl = 3'($urandom_range(0, 5));
                ae_lvl = 3'($urandom_range(0, 5));
            end
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
